ram_rd_check: RTL
=================

// Module: ram_rd_check
// PURPOSE
//  Port-B read side of the 2-port RAM test pair. Waits for the writer's rd_flag, then
//  sweeps port B through addresses 0..DEPTH-1 continuously. Checks each returned word
//  against the write pattern: {zero pad, address}.
//  Reports a sticky error flag, a saturating error count, the first failing address
//  and a one-cycle pulse per completed sweep. Sits directly downstream of the port-A
//  writer, which provides rd_flag.
// PARAMETERS
//  ADDR_W  6   RAM address width; DEPTH = 2**ADDR_W words
//  DATA_W  8   RAM data width; must be >= ADDR_W
//  RD_LAT  1   RAM port-B read latency in clk cycles (legal 1..3)
//  CNT_W   16  width of err_cnt
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  rd_flag      in   1       start/continue reading (from writer, level)
//  ram_rd_en    out  1       port-B enable
//  ram_rd_addr  out  ADDR_W  port-B read address
//  ram_rd_data  in   DATA_W  port-B read data, valid RD_LAT cycles after en/addr
//  chk_valid    out  1       a returned word is being compared this cycle
//  err_flag     out  1       sticky: any mismatch since reset
//  err_cnt      out  CNT_W   mismatch count, saturates at all-ones
//  err_addr     out  ADDR_W  address of first mismatch (0 until err_flag)
//  pass_done    out  1       1-cycle pulse when the word at DEPTH-1 has been checked
// BEHAVIOUR
//  Reset (async, all registers): FSM=IDLE, ram_rd_en=0, ram_rd_addr=0, chk_valid=0,
//   err_flag=0, err_cnt=0, err_addr=0, pass_done=0, latency pipeline cleared.
//  FSM states:
//   - IDLE: ram_rd_en=0, ram_rd_addr=0. rd_flag sampled 1 -> READ on the next edge.
//     ram_rd_en rises one cycle after rd_flag is first seen high.
//   - READ: ram_rd_en=1. ram_rd_addr increments by 1 each cycle and wraps
//     DEPTH-1 -> 0 with no gap. rd_flag sampled 0 -> IDLE; the address issued on
//     that cycle is the last one.
//  Check pipeline: a RD_LAT-deep shift register of {en, addr}.
//   - Stage RD_LAT output gives chk_valid and the expected address exp_addr.
//   - Compare ram_rd_data == {(DATA_W-ADDR_W)'b0, exp_addr} only when chk_valid=1.
//   - ram_rd_data is ignored when chk_valid=0.
//   - In-flight reads still drain and are checked after leaving READ.
//  Mismatch with chk_valid=1 on cycle t. Updates are registered and visible at t+1:
//   - err_cnt+1, holding at all-ones once saturated.
//   - err_flag set; it is cleared only by reset.
//   - err_addr loaded only if err_flag was 0 on cycle t.
//  pass_done: registered pulse, high the cycle after chk_valid=1 with exp_addr=DEPTH-1.
//   Fires regardless of mismatch.
//  Re-entering READ after IDLE restarts the sweep at address 0.
//  rd_flag toggling mid-sweep is legal; no error or count state is touched by FSM moves.
//  Reset asserted mid-operation: everything returns to reset values immediately.
//   No pending compare or pulse survives.
// TESTING
//  1 Reset, rd_flag=0 for 20 cyc -> ram_rd_en=0, chk_valid=0, all status outputs 0.
//  2 rd_flag=1 at cyc 0, RAM model holds addr pattern, RD_LAT=1:
//    - en=1 at cyc 1, addr 0..63 at cyc 1..64, 0 again at cyc 65.
//    - chk_valid at cyc 2; pass_done high at cyc 66; err_cnt=0.
//  3 Corrupt word 10 to 8'hFF and word 40 to 8'h00 -> err_flag=1, err_addr=10,
//    err_cnt=2 after the first sweep and 4 after the second sweep.
//  4 Drop rd_flag when addr=20 is issued, RD_LAT=2 -> en=0 the next cycle.
//    - Checks for 19 and 20 still occur; addr returns to 0; no pass_done.
//    - On re-raise, the sweep restarts at 0.
//  5 CNT_W=4, all words corrupt -> err_cnt stops at 4'hF; err_addr stays at the first failure.
//  6 Assert rst_n=0 mid-sweep with err_flag=1 -> all outputs 0 asynchronously.
//    - The next rd_flag restarts cleanly at address 0.

Source files
------------

// File: rtl/ram_rd_check.sv
// Port-B read checker for the two-port RAM test pair.
// Once the writer raises rd_flag, it sweeps addresses 0..DEPTH-1 without stopping and
// compares each returned word with the address-derived write pattern. It reports a
// sticky error flag, a saturating error count, the first failing address and a
// pulse at the end of each sweep.
module ram_rd_check #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,   // must be >= ADDR_W
  parameter int RD_LAT = 1,   // port-B read latency, 1..3
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_flag,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              chk_valid,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              pass_done
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Tracks each issued {en, addr} until its data returns RD_LAT cycles later.
  logic [RD_LAT-1:0] pipe_en;
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];

  logic [ADDR_W-1:0] exp_addr;
  logic              mismatch;

  // State and address registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic. Entering READ always restarts the sweep at address 0.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latch).
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (rd_flag) state_d = READ;
      end
      READ: begin
        if (rd_flag) begin
          addr_d = addr_q + ADDR_W'(1);  // wraps from DEPTH-1 to 0 with no gap
        end else begin
          state_d = IDLE;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  assign ram_rd_en   = (state_q == READ);
  assign ram_rd_addr = addr_q;

  // Latency pipeline. Reads already in flight keep draining after the FSM leaves READ.
  // NOTE: this small array is reset with a loop so no stale compare survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_en <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_en[0]   <= ram_rd_en;
      pipe_addr[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign chk_valid = pipe_en[RD_LAT-1];
  assign exp_addr  = pipe_addr[RD_LAT-1];
  assign mismatch  = chk_valid && (ram_rd_data != DATA_W'(exp_addr));

  // Error status and end-of-sweep pulse. FSM moves never touch these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag  <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      pass_done <= 1'b0;
    end else begin
      pass_done <= chk_valid && (exp_addr == '1);
      if (mismatch) begin
        err_flag <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (!err_flag) err_addr <= exp_addr;
      end
    end
  end

endmodule
